// File: rtl/non_restoring_divider_signed.sv
// non_restoring_divider_signed: iterative signed/unsigned non-restoring divider, one quotient bit per cycle.
// Define DIVIDER_EARLY_OUT_EN to finish trivial divisions (x/0, MIN/-1, |dividend| < |divisor|) straight from IDLE.
module non_restoring_divider_signed #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  signed_i,
    input  logic                  data_valid_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  overflow_o,
    output logic                  data_valid_o,
    output logic                  idle_o
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, RESTORE, DONE} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [W:0] rem, rem_sh, rem_nx;
    logic [W-1:0] quot, dvs, dvd, dvd_mag, dvs_mag, r_mag;
    logic neg_q, neg_r, dz, ovf, dz_in, ovf_in, early, start;

    assign start   = state == IDLE && data_valid_i;
    assign dvd_mag = signed_i && dividend_i[W-1] ? -dividend_i : dividend_i;
    assign dvs_mag = signed_i && divisor_i[W-1] ? -divisor_i : divisor_i;
    assign dz_in   = divisor_i == '0;
    assign ovf_in  = signed_i && dividend_i == MIN && divisor_i == '1;
`ifdef DIVIDER_EARLY_OUT_EN
    // a zero dividend is covered by the magnitude compare (divisor 0 is dz)
    assign early = dz_in || ovf_in || dvd_mag < dvs_mag;
`else
    assign early = 1'b0;
`endif

    // W+1 bit partial remainder; wrap in the shifted value is harmless because
    // every post-add/subtract remainder lies in [-dvs, dvs-1]
    assign rem_sh = {rem[W-1:0], quot[W-1]};
    assign rem_nx = rem[W] ? rem_sh + {1'b0, dvs} : rem_sh - {1'b0, dvs};
    assign r_mag  = rem[W] ? rem[W-1:0] + dvs : rem[W-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            state <= IDLE;
        else if (clk_en_i)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = data_valid_i ? (early ? DONE : DIVIDE) : IDLE;
            DIVIDE:  state_nx = cnt == CW'(W - 1) ? RESTORE : DIVIDE;
            RESTORE: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        data_valid_o = state == DONE;
        idle_o       = state == IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt              <= '0;
            rem              <= '0;
            quot             <= '0;
            dvs              <= '0;
            dvd              <= '0;
            neg_q            <= 1'b0;
            neg_r            <= 1'b0;
            dz               <= 1'b0;
            ovf              <= 1'b0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            divide_by_zero_o <= 1'b0;
            overflow_o       <= 1'b0;
        end else if (clk_en_i) begin
            if (start) begin
                dvs   <= dvs_mag;
                dvd   <= dividend_i;
                rem   <= '0;
                quot  <= dvd_mag;
                cnt   <= '0;
                neg_q <= signed_i && (dividend_i[W-1] ^ divisor_i[W-1]);
                neg_r <= signed_i && dividend_i[W-1];
                dz    <= dz_in;
                ovf   <= ovf_in;
            end
            if (start && early) begin
                quotient_o       <= dz_in ? '1 : ovf_in ? MIN : '0;
                remainder_o      <= ovf_in ? '0 : dividend_i;
                divide_by_zero_o <= dz_in;
                overflow_o       <= ovf_in;
            end
            if (state == DIVIDE) begin
                rem  <= rem_nx;
                quot <= {quot[W-2:0], ~rem_nx[W]};
                cnt  <= cnt + 1'b1;
            end
            if (state == RESTORE) begin
                quotient_o       <= dz ? '1 : ovf ? MIN : neg_q ? -quot : quot;
                remainder_o      <= dz ? dvd : ovf ? '0 : neg_r ? -r_mag : r_mag;
                divide_by_zero_o <= dz;
                overflow_o       <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_non_restoring_divider_signed.sv
// tb_non_restoring_divider_signed: directed and random divisions against an arithmetic reference model.
module tb_non_restoring_divider_signed;
    localparam int W = 8;

    logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, sgn = 1'b0, dvi = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
    logic dz, ovf, dvo, idle;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    non_restoring_divider_signed #(.DATA_WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
        .dividend_i(dividend), .divisor_i(divisor), .signed_i(sgn), .data_valid_i(dvi),
        .quotient_o(quotient), .remainder_o(remainder), .divide_by_zero_o(dz),
        .overflow_o(ovf), .data_valid_o(dvo), .idle_o(idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mag(logic [7:0] v, bit s);
        return (s && v[7]) ? 256 - int'(v) : int'(v);
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit s, input int stall);
        logic [7:0] eq, er;
        bit edz, eovf, early;
        int exp_lat, n;
        string op;
        op = $sformatf("%s %h/%h", s ? "s" : "u", a, b);
        edz  = b == 8'h00;
        eovf = s && a == 8'h80 && b == 8'hff;
        if (edz) begin
            eq = 8'hff; er = a;
        end else if (eovf) begin
            eq = 8'h80; er = 8'h00;
        end else if (s) begin
            eq = 8'($signed(a) / $signed(b));
            er = 8'($signed(a) % $signed(b));
        end else begin
            eq = a / b;
            er = a % b;
        end
`ifdef DIVIDER_EARLY_OUT_EN
        early = edz || eovf || mag(a, s) < mag(b, s);
`else
        early = 1'b0;
`endif
        exp_lat = early ? 1 : W + 2 + stall;
        check({"idle_before ", op}, idle, 1);
        dividend = a; divisor = b; sgn = s; dvi = 1'b1;
        @(negedge clk);
        dvi = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom); sgn = 1'($urandom);
        n = 1;
        while (!dvo && n < 40) begin
            clk_en = !(n >= 3 && n < 3 + stall);
            dvi = n == 2;
            @(negedge clk);
            n++;
        end
        clk_en = 1'b1; dvi = 1'b0;
        check({"latency ", op}, n, exp_lat);
        check({"quot ", op}, quotient, eq);
        check({"rem ", op}, remainder, er);
        check({"dz ", op}, dz, edz);
        check({"ovf ", op}, ovf, eovf);
        check({"idle_in_done ", op}, idle, 0);
        @(negedge clk);
        check({"strobe_len ", op}, dvo, 0);
        check({"idle_after ", op}, idle, 1);
    endtask

    initial begin
        int strobes;
        logic [7:0] a, b;
        int k;
        repeat (3) @(negedge clk);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dz", dz, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid", dvo, 0);
        check("rst_idle", idle, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'hC8, 8'h07, 1'b0, 0);
        run_op(8'hF9, 8'h02, 1'b1, 0);
        run_op(8'h07, 8'hFE, 1'b1, 0);
        run_op(8'h85, 8'h00, 1'b1, 0);
        run_op(8'h85, 8'h00, 1'b0, 0);
        run_op(8'h80, 8'hFF, 1'b1, 0);
        run_op(8'h80, 8'hFF, 1'b0, 0);
        run_op(8'h03, 8'h0A, 1'b0, 0);
        run_op(8'hC8, 8'h07, 1'b0, 3);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'h01, 1'b1, 0);
        run_op(8'h7F, 8'h80, 1'b1, 0);

        // abort an operation in DIVIDE cycle 4; outputs still hold 0x7F from above
        dividend = 8'hC8; divisor = 8'h07; sgn = 1'b0; dvi = 1'b1;
        @(negedge clk);
        dvi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_quot", quotient, 0);
        check("abort_rem", remainder, 0);
        check("abort_idle", idle, 1);
        check("abort_valid", dvo, 0);
        strobes = 0;
        repeat (14) begin
            @(negedge clk);
            strobes += int'(dvo);
        end
        check("abort_no_strobe", strobes, 0);

        repeat (300) begin
            k = $urandom_range(0, 7);
            a = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
            b = k == 0 ? 8'h00 : k == 1 ? 8'hFF : k == 2 ? 8'($urandom_range(1, 15)) : 8'($urandom);
            run_op(a, b, 1'($urandom), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/non_restoring_divider_signed.md
Name: non_restoring_divider_signed

Overview:
- Second-generation iterative non-restoring divider for the Integer/Dividers library.
- Divides two DATA_WIDTH-bit operands, signed or unsigned as selected per operation, at one quotient bit per cycle.
- Fixes gaps in the first-generation unsigned divider: accepts any width, handles dividend < divisor, defines divide-by-zero and signed-overflow results, and registers all outputs.
- Used as the shared multi-cycle divide unit behind integer ALUs.

Parameters:
- DATA_WIDTH, 16, operand and result width in bits; any value >= 2, not restricted to powers of 2.

Ports:
- clk_i  input  1  clock; all registers update on rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- clk_en_i  input  1  clock enable; when low, every register holds.
- dividend_i  input  DATA_WIDTH  dividend; sampled on the accepting edge only.
- divisor_i  input  DATA_WIDTH  divisor; sampled on the accepting edge only.
- signed_i  input  1  1 = two's-complement operation, 0 = unsigned; sampled with the operands.
- data_valid_i  input  1  start request; honoured only in IDLE.
- quotient_o  output  DATA_WIDTH  registered quotient; holds until the next result.
- remainder_o  output  DATA_WIDTH  registered remainder; holds until the next result.
- divide_by_zero_o  output  1  registered; valid with the result.
- overflow_o  output  1  registered; signed MIN / -1 flag, valid with the result.
- data_valid_o  output  1  one-cycle result strobe.
- idle_o  output  1  high in IDLE; a start is accepted only while this is high.

Behaviour:
- Reset: state=IDLE; quotient_o, remainder_o, divide_by_zero_o, overflow_o and data_valid_o = 0; idle_o = 1.
- Reset mid-operation aborts the operation; no data_valid_o is produced.
- States: IDLE, DIVIDE, RESTORE, DONE.
- IDLE:
  - Accepting edge: data_valid_i=1 and clk_en_i=1.
  - On acceptance, latch |dividend| and |divisor|. Magnitudes are taken only when signed_i=1; in signed mode, MIN magnitude = 2^(W-1) as unsigned.
  - Also latch the signs and signed_i, clear the partial remainder (W+1 bits including sign), clear the counter, then go to DIVIDE.
- DIVIDE: exactly DATA_WIDTH cycles. Each cycle:
  - Shift {rem, quot} left by 1.
  - Add the divisor if the previous remainder is negative, else subtract it.
  - Quotient LSB = NOT(new remainder sign).
  - Counter width = $clog2(DATA_WIDTH+1); after the last iteration go to RESTORE.
- RESTORE: 1 cycle.
  - If the remainder is negative, add the divisor.
  - Signed mode: negate the quotient when sign(dividend) XOR sign(divisor); negate the remainder when sign(dividend)=1.
  - Apply the overrides below, load the output registers, go to DONE.
- Divisor = 0, both modes:
  - quotient_o = all ones, remainder_o = original dividend, divide_by_zero_o = 1.
  - Sign correction is overridden.
- Signed dividend = MIN with divisor = all ones:
  - quotient_o = MIN, remainder_o = 0, overflow_o = 1.
- Otherwise both flags are 0.
- DONE: data_valid_o=1 and idle_o=0 for one cycle, then return to IDLE.
- Latency: data_valid_o is high in the (DATA_WIDTH+2)th enabled cycle after the accepting edge.
- Throughput: a new start is possible on the cycle after DONE.
- data_valid_i is ignored outside IDLE; input changes after acceptance have no effect.
- Dividend < divisor is handled by the normal algorithm: quotient 0, remainder = dividend.
- clk_en_i low: state, counter, datapath and outputs all freeze. A strobe in progress stays high until the next enabled edge.

Optional Feature:
- Macro: DIVIDER_EARLY_OUT_EN.
- Defined: in IDLE, detect divisor = 0, signed overflow, dividend = 0, or |dividend| < |divisor|. In these cases skip DIVIDE and RESTORE, load the final results directly, and go to DONE. data_valid_o then rises on the 1st enabled cycle after acceptance. All other operations keep the DATA_WIDTH+2 latency.
- Not defined: every operation takes DATA_WIDTH+2 cycles; detection logic is absent.

Test Plan (DATA_WIDTH=8):
- Unsigned 200/7 (0xC8/0x07) -> quotient 0x1C, remainder 0x04, flags 0, data_valid_o high one cycle at cycle 10.
- Signed -7/2 (0xF9/0x02) -> quotient 0xFD, remainder 0xFF; signed 7/-2 (0x07/0xFE) -> quotient 0xFD, remainder 0x01.
- Signed 0x85/0x00 -> quotient 0xFF, remainder 0x85, divide_by_zero_o=1. Unsigned 0x85/0x00 gives the same result.
- Signed 0x80/0xFF -> quotient 0x80, remainder 0x00, overflow_o=1; unsigned 0x80/0xFF -> quotient 0, remainder 0x80, overflow_o=0.
- Unsigned 3/10 -> quotient 0, remainder 3. Strobe at cycle 10 without the macro, cycle 1 with DIVIDER_EARLY_OUT_EN.
- rst_n_i low at DIVIDE cycle 4 -> outputs 0, idle_o=1, no strobe. clk_en_i low for 3 cycles mid-DIVIDE -> correct result, latency grows by exactly 3.
